// File: rtl/vote_if.sv
// Vote handshake bundle between the voter front-end and its clients.
// Carries per-vote inputs and the assembled round result.
interface vote_if;
  logic       start;
  logic       vote_valid;
  logic [2:0] vote_id;
  logic       vote_val;
  logic       vote_ready;
  logic [6:0] votes_out;
  logic [6:0] voted_mask;
  logic       votes_valid;
  logic       timeout_flag;
  logic       dup_err;
  logic       busy;

  modport master (
    output start, vote_valid, vote_id, vote_val,
    input  vote_ready, votes_out, voted_mask,
    input  votes_valid, timeout_flag, dup_err, busy
  );

  modport slave (
    input  start, vote_valid, vote_id, vote_val,
    output vote_ready, votes_out, voted_mask,
    output votes_valid, timeout_flag, dup_err, busy
  );
endinterface

// File: rtl/vote_collector.sv
// Collects one vote per cycle from 7 voters into a vector for the
// majority voter; a round ends on a full mask or on timeout.
module vote_collector #(
  parameter int N_VOTERS       = 7,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TMR_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
  input logic   clk,
  input logic   rst_n,
  vote_if.slave vif
);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [6:0]       votes_q, mask_q;
  logic [6:0]       id_bit, mask_d, votes_d;
  logic             tflag_q, dup_q;
  logic [TMR_W-1:0] timer_q;
  logic             in_col, fire, id_ok;
  logic             take, bad, full_d, tmr_end;

  assign in_col  = state_q == COLLECT;
  assign fire    = in_col & vif.vote_valid;
  assign id_ok   = {1'b0, vif.vote_id} < 4'(N_VOTERS);
  assign id_bit  = id_ok ? 7'(1) << vif.vote_id : '0;
  assign take    = fire & id_ok & ~|(mask_q & id_bit);
  assign bad     = fire & ~take;
  assign mask_d  = take ? (mask_q | id_bit) : mask_q;
  assign full_d  = &mask_d;
  assign tmr_end = timer_q == TMR_W'(TIMEOUT_CYCLES - 1);

  always_comb begin
    votes_d = votes_q;
    if (take) begin
      votes_d = vif.vote_val ? (votes_q | id_bit)
                             : (votes_q & ~id_bit);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Completion takes priority over a timeout in the same cycle
  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q == IDLE: if (vif.start) state_d = COLLECT;
      in_col:          if (full_d || tmr_end) state_d = DONE;
      state_q == DONE: state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      votes_q <= '0;
      mask_q  <= '0;
      tflag_q <= 1'b0;
      dup_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      dup_q <= 1'b0;
      if (state_q == IDLE && vif.start) begin
        votes_q <= '0;
        mask_q  <= '0;
        tflag_q <= 1'b0;
        timer_q <= '0;
      end
      if (in_col) begin
        timer_q <= timer_q + TMR_W'(1);
        votes_q <= votes_d;
        mask_q  <= mask_d;
        dup_q   <= bad;
        if (tmr_end && !full_d) tflag_q <= 1'b1;
      end
    end
  end

  assign vif.vote_ready   = in_col;
  assign vif.busy         = state_q != IDLE;
  assign vif.votes_valid  = state_q == DONE;
  assign vif.votes_out    = votes_q;
  assign vif.voted_mask   = mask_q;
  assign vif.timeout_flag = tflag_q;
  assign vif.dup_err      = dup_q;

endmodule

// File: tb/tb_vote_collector.sv
// Scoreboard bench for vote_collector: a round-level model predicts
// each result; a monitor checks it when votes_valid appears.
module tb_vote_collector;

  localparam int TO = 16;

  typedef struct {
    logic [6:0] votes;
    logic [6:0] mask;
    logic       tflag;
    int         cycles;
    int         dups;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  exp_t sb[$];
  exp_t mon_e;
  int   busy_cnt;
  int   dup_cnt;
  logic [6:0] last_votes;
  logic       last_tf;

  logic       vv[TO];
  logic [2:0] vid[TO];
  logic       vval[TO];

  vote_if vif ();

  vote_collector #(
    .N_VOTERS      (7),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .vif  (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Round result from the voting rules, cycle by cycle of COLLECT
  function automatic exp_t model();
    exp_t e;
    int   idx;
    e = '{default: 0};
    e.cycles = TO;
    for (int k = 0; k < TO; k++) begin
      if (vv[k]) begin
        idx = int'(vid[k]);
        if (idx >= 7 || e.mask[idx]) begin
          e.dups++;
        end else begin
          e.mask[idx]  = 1'b1;
          e.votes[idx] = vval[k];
        end
      end
      if (e.mask == 7'h7F) begin
        e.cycles = k + 1;
        return e;
      end
    end
    e.tflag = 1'b1;
    return e;
  endfunction

  task automatic clr_stim();
    for (int k = 0; k < TO; k++) begin
      vv[k]   = 1'b0;
      vid[k]  = 3'($urandom_range(0, 7));
      vval[k] = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic put(input int k, input int id, input logic v);
    vv[k]   = 1'b1;
    vid[k]  = 3'(id);
    vval[k] = v;
  endtask

  // Called at posedge+1 in IDLE; leaves the bench in the next IDLE
  task automatic run_round();
    exp_t e;
    e = model();
    sb.push_back(e);
    vif.start = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < e.cycles; k++) begin
      vif.vote_valid = vv[k];
      vif.vote_id    = vid[k];
      vif.vote_val   = vval[k];
      vif.start      = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    vif.vote_valid = 1'b0;
    vif.vote_id    = 3'($urandom_range(0, 7));
    vif.vote_val   = 1'($urandom_range(0, 1));
    vif.start      = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    vif.start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".vote_ready"}, 32'(vif.vote_ready), 0);
    chk({tag, ".busy"}, 32'(vif.busy), 0);
    chk({tag, ".votes_valid"}, 32'(vif.votes_valid), 0);
    chk({tag, ".votes_out"}, 32'(vif.votes_out), 0);
    chk({tag, ".voted_mask"}, 32'(vif.voted_mask), 0);
    chk({tag, ".timeout_flag"}, 32'(vif.timeout_flag), 0);
    chk({tag, ".dup_err"}, 32'(vif.dup_err), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt   = 0;
      dup_cnt    = 0;
      last_votes = '0;
      last_tf    = 1'b0;
    end else begin
      if (vif.dup_err) dup_cnt++;
      if (vif.busy) busy_cnt++;
      if (vif.votes_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_votes_valid", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("votes_out", 32'(vif.votes_out), 32'(mon_e.votes));
          chk("voted_mask", 32'(vif.voted_mask), 32'(mon_e.mask));
          chk("timeout_flag", 32'(vif.timeout_flag),
              32'(mon_e.tflag));
          chk("round_len", 32'(busy_cnt), 32'(mon_e.cycles + 1));
          chk("dup_pulses", 32'(dup_cnt), 32'(mon_e.dups));
          chk("ready_in_done", 32'(vif.vote_ready), 0);
          last_votes = mon_e.votes;
          last_tf    = mon_e.tflag;
        end
        busy_cnt = 0;
        dup_cnt  = 0;
      end else if (vif.busy) begin
        chk("ready_in_collect", 32'(vif.vote_ready), 1);
      end else begin
        chk("idle_hold_votes", 32'(vif.votes_out), 32'(last_votes));
        chk("idle_hold_tflag", 32'(vif.timeout_flag), 32'(last_tf));
        chk("idle_ready", 32'(vif.vote_ready), 0);
        chk("idle_dup", 32'(vif.dup_err), 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks         = 0;
    errors         = 0;
    rst_n          = 1'b0;
    vif.start      = 1'b0;
    vif.vote_valid = 1'b0;
    vif.vote_id    = '0;
    vif.vote_val   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_zero("idle");

    // full round: yes from voters 0..2, no from 3..6
    clr_stim();
    for (int k = 0; k < 7; k++) put(k, k, k < 3);
    run_round();

    // timeout with only voters 2 and 5 (back-to-back start)
    clr_stim();
    put(0, 2, 1'b1);
    put(1, 5, 1'b1);
    run_round();

    // duplicate then illegal id
    clr_stim();
    put(0, 3, 1'b1);
    put(1, 3, 1'b0);
    put(2, 7, 1'b1);
    run_round();

    // seventh vote lands on the final timeout cycle
    clr_stim();
    for (int k = 0; k < 6; k++) put(k, k, 1'($urandom_range(0, 1)));
    put(TO - 1, 6, 1'b1);
    run_round();

    // mid-round reset after four votes
    vif.start = 1'b1;
    @(posedge clk); #1;
    vif.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      vif.vote_valid = 1'b1;
      vif.vote_id    = 3'(k);
      vif.vote_val   = 1'b1;
      @(posedge clk); #1;
    end
    vif.vote_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk_zero("mid_reset");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int r = 0; r < 40; r++) begin
      int mode;
      int off;
      clr_stim();
      mode = $urandom_range(0, 2);
      off  = $urandom_range(0, 6);
      for (int k = 0; k < TO; k++) begin
        if (mode == 0) begin
          if (k < 7) put(k, (k * 3 + off) % 7, 1'($urandom_range(0, 1)));
        end else if (mode == 1) begin
          if ($urandom_range(0, 5) == 0)
            put(k, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        end else begin
          if ($urandom_range(0, 3) != 0)
            put(k, $urandom_range(0, 7), 1'($urandom_range(0, 1)));
        end
      end
      run_round();
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
